// File: rtl/stream_xor_compactor_pkg.sv
// Shared types and elaboration helpers for the stream XOR compactor.
package stream_xor_compactor_pkg;

   // Run-framing FSM states (2-bit encoding)
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   // Width of the DRAIN cycle counter
   localparam int DRAIN_CNT_W = 8;

   // Number of registered XOR-tree levels for n leaves (0 for a single leaf)
   function automatic int tree_levels(input int n);
      return (n <= 1) ? 0 : $clog2(n);
   endfunction

   // Number of live nodes at tree level lvl for n leaves
   function automatic int lvl_n(input int n, input int lvl);
      return (n + (1 << lvl) - 1) >> lvl;
   endfunction

endpackage

// File: rtl/stream_xor_compactor_xor_fold.sv
// Combinational slice-XOR: folds an IN_W-bit word into OUT_W bits.
module xor_fold
   import stream_xor_compactor_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int OUT_W = 8
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout
);

   localparam int N_SLICE = IN_W / OUT_W;

   // XOR every OUT_W-wide slice of the input together
   always_comb begin
      dout = '0;
      for (int i = 0; i < N_SLICE; i++) begin
         dout = dout ^ din[i*OUT_W +: OUT_W];
      end
   end

endmodule

// File: rtl/stream_xor_compactor.sv
// Folds NUM_CH kernel write streams through a pipelined XOR tree onto a narrow
// pin bus, and keeps a per-run rotate-XOR signature plus a saturating word count.
module stream_xor_compactor
   import stream_xor_compactor_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int DIN_WIDTH  = 32,
   parameter int FOLD_WIDTH = 8,
   parameter int OUT_WIDTH  = 4,
   parameter int SIG_WIDTH  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst_n,
   input  logic                        ap_start,
   input  logic                        ap_done,
   input  logic [NUM_CH*DIN_WIDTH-1:0] ch_din,
   input  logic [NUM_CH-1:0]           ch_write,
   output logic [OUT_WIDTH-1:0]        data_out,
   output logic                        data_valid,
   output logic [SIG_WIDTH-1:0]        sig_out,
   output logic                        sig_valid,
   output logic [CNT_WIDTH-1:0]        word_count,
   output logic                        busy
);

   localparam int L         = tree_levels(NUM_CH);
   localparam int DRAIN_CYC = 2 + L;
   localparam int WIDE_W    = CNT_WIDTH + 32;
   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYC - 1);

   if (NUM_CH < 1) begin : g_chk_ch
      $error("NUM_CH must be at least 1");
   end
   if (DIN_WIDTH % FOLD_WIDTH != 0) begin : g_chk_din
      $error("DIN_WIDTH must be a multiple of FOLD_WIDTH");
   end
   if (FOLD_WIDTH % OUT_WIDTH != 0) begin : g_chk_fold
      $error("FOLD_WIDTH must be a multiple of OUT_WIDTH");
   end
   if (SIG_WIDTH < FOLD_WIDTH) begin : g_chk_sig
      $error("SIG_WIDTH must be at least FOLD_WIDTH");
   end

   function automatic logic [31:0] popcount(input logic [NUM_CH-1:0] v);
      logic [31:0] n;
      n = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [31:0] b);
      logic [WIDE_W-1:0] sum;
      sum = WIDE_W'(a) + WIDE_W'(b);
      if (|sum[WIDE_W-1:CNT_WIDTH]) begin
         return '1;
      end
      return sum[CNT_WIDTH-1:0];
   endfunction

   function automatic logic [SIG_WIDTH-1:0] rotl1(input logic [SIG_WIDTH-1:0] s);
      return {s[SIG_WIDTH-2:0], s[SIG_WIDTH-1]};
   endfunction

   state_t                   state, state_nxt;
   logic                     start_q;
   logic                     start_rise;
   logic [DRAIN_CNT_W-1:0]   drain_cnt;
   logic                     drain_last;
   logic                     counting;

   logic [NUM_CH*FOLD_WIDTH-1:0] fold_p0;
   logic [NUM_CH*FOLD_WIDTH-1:0] fold_p1;
   logic [NUM_CH-1:0]            vld_p1;
   logic                         tag_p1;

   logic [FOLD_WIDTH-1:0] root_dat;
   logic                  root_vld;
   logic                  root_tag;
   logic [OUT_WIDTH-1:0]  out_fold;

   logic [SIG_WIDTH-1:0]  sig, sig_nxt;

   assign start_rise = ap_start & ~start_q;
   assign counting   = (state == ST_RUN) || (state == ST_DRAIN);
   assign drain_last = (drain_cnt == DRAIN_LAST);
   assign busy       = counting;
   assign sig_valid  = (state == ST_REPORT);

   // State register, start-edge history and DRAIN length counter
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state     <= ST_IDLE;
         start_q   <= 1'b0;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         start_q   <= ap_start;
         drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
      end
   end

   // Next-state logic; start edges outside IDLE and done outside RUN are ignored
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start_rise) state_nxt = ST_RUN;
         ST_RUN:    if (ap_done)    state_nxt = ST_DRAIN;
         ST_DRAIN:  if (drain_last) state_nxt = ST_REPORT;
         ST_REPORT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      xor_fold #(.IN_W(DIN_WIDTH), .OUT_W(FOLD_WIDTH)) u_fold (
         .din  (ch_din[c*DIN_WIDTH +: DIN_WIDTH]),
         .dout (fold_p0[c*FOLD_WIDTH +: FOLD_WIDTH])
      );
   end

   // S1: per-channel folds with write strobes and run tag
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         fold_p1 <= '0;
         vld_p1  <= '0;
         tag_p1  <= 1'b0;
      end else begin
         fold_p1 <= fold_p0;
         vld_p1  <= ch_write;
         tag_p1  <= counting;
      end
   end

   for (genvar l = 0; l <= L; l++) begin : g_lvl
      localparam int N = lvl_n(NUM_CH, l);
      logic [N*FOLD_WIDTH-1:0] dat;
      logic [N-1:0]            vld;
      logic                    tag;

      if (l == 0) begin : g_leaf
         assign dat = fold_p1;
         assign vld = vld_p1;
         assign tag = tag_p1;
      end else begin : g_node
         localparam int NP = lvl_n(NUM_CH, l - 1);
         localparam int PW = 2 * N * FOLD_WIDTH;
         logic [PW-1:0]           pd;
         logic [2*N-1:0]          pv;
         logic [N*FOLD_WIDTH-1:0] dat_nxt;
         logic [N-1:0]            vld_nxt;

         assign pd = PW'(g_lvl[l-1].dat);
         assign pv = (2*N)'(g_lvl[l-1].vld);

         // Pair neighbours: XOR of the valid members; an odd tail passes through
         always_comb begin
            dat_nxt = '0;
            vld_nxt = '0;
            for (int i = 0; i < N; i++) begin
               if (2*i + 1 < NP) begin
                  dat_nxt[i*FOLD_WIDTH +: FOLD_WIDTH] =
                     (pv[2*i]   ? pd[(2*i)*FOLD_WIDTH +: FOLD_WIDTH]   : '0) ^
                     (pv[2*i+1] ? pd[(2*i+1)*FOLD_WIDTH +: FOLD_WIDTH] : '0);
                  vld_nxt[i] = pv[2*i] | pv[2*i+1];
               end else begin
                  dat_nxt[i*FOLD_WIDTH +: FOLD_WIDTH] = pd[(2*i)*FOLD_WIDTH +: FOLD_WIDTH];
                  vld_nxt[i] = pv[2*i];
               end
            end
         end

         // Tree level register; the run tag travels with the level
         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               dat <= '0;
               vld <= '0;
               tag <= 1'b0;
            end else begin
               dat <= dat_nxt;
               vld <= vld_nxt;
               tag <= g_lvl[l-1].tag;
            end
         end
      end
   end

   assign root_dat = g_lvl[L].dat;
   assign root_vld = g_lvl[L].vld;
   assign root_tag = g_lvl[L].tag;

   xor_fold #(.IN_W(FOLD_WIDTH), .OUT_W(OUT_WIDTH)) u_out_fold (
      .din  (root_dat),
      .dout (out_fold)
   );

   // S3: narrow output word, forced to zero when not valid
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_out   <= root_vld ? out_fold : '0;
         data_valid <= root_vld;
      end
   end

   // Signature step for roots that entered the pipe while a run was open
   always_comb begin
      sig_nxt = sig;
      if (root_vld && root_tag) begin
         sig_nxt = rotl1(sig) ^ SIG_WIDTH'(root_dat);
      end
   end

   // Run accumulators: cleared on run entry, signature captured on DRAIN exit
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         sig        <= '0;
         word_count <= '0;
         sig_out    <= '0;
      end else begin
         if (state == ST_IDLE && start_rise) begin
            sig        <= '0;
            word_count <= '0;
         end else begin
            sig <= sig_nxt;
            if (counting) begin
               word_count <= sat_add(word_count, popcount(ch_write));
            end
         end
         if (state == ST_DRAIN && drain_last) begin
            sig_out <= sig_nxt;
         end
      end
   end

endmodule

// File: tb/tb_stream_xor_compactor.sv
// Scoreboard bench for stream_xor_compactor: default build plus a 3-channel,
// 4-bit-counter build sharing the clock and reset.
module tb_stream_xor_compactor;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        ap_start, ap_done;
   logic [63:0] ch_din;
   logic [1:0]  ch_write;
   logic [3:0]  data_out;
   logic        data_valid;
   logic [15:0] sig_out;
   logic        sig_valid;
   logic [15:0] word_count;
   logic        busy;

   logic        b_start, b_done;
   logic [95:0] b_din;
   logic [2:0]  b_write;
   logic [3:0]  b_data_out;
   logic        b_data_valid;
   logic [15:0] b_sig_out;
   logic        b_sig_valid;
   logic [3:0]  b_word_count;
   logic        b_busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [3:0] d;
      int         due;
   } exp_t;
   exp_t sb[$];

   always #5 ap_clk = ~ap_clk;
   always @(posedge ap_clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   stream_xor_compactor dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
      .ch_din(ch_din), .ch_write(ch_write), .data_out(data_out), .data_valid(data_valid),
      .sig_out(sig_out), .sig_valid(sig_valid), .word_count(word_count), .busy(busy)
   );

   stream_xor_compactor #(.NUM_CH(3), .CNT_WIDTH(4)) dut_b (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(b_start), .ap_done(b_done),
      .ch_din(b_din), .ch_write(b_write), .data_out(b_data_out), .data_valid(b_data_valid),
      .sig_out(b_sig_out), .sig_valid(b_sig_valid), .word_count(b_word_count), .busy(b_busy)
   );

   function automatic logic [7:0] fold8(input logic [31:0] x);
      return x[31:24] ^ x[23:16] ^ x[15:8] ^ x[7:0];
   endfunction

   function automatic logic [3:0] fold4(input logic [7:0] x);
      return x[7:4] ^ x[3:0];
   endfunction

   function automatic logic [15:0] rotl(input logic [15:0] s);
      return {s[14:0], s[15]};
   endfunction

   task automatic test_reset();
      ap_rst_n = 1'b0; ap_start = 1'b0; ap_done = 1'b0; ch_din = '0; ch_write = '0;
      b_start = 1'b0; b_done = 1'b0; b_din = '0; b_write = '0;
      repeat (3) @(negedge ap_clk);
      checks++;
      if ({data_out, data_valid, sig_out, sig_valid, word_count, busy} !== 39'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0",
                  {data_out, data_valid, sig_out, sig_valid, word_count, busy});
      end
      checks++;
      if ({b_data_out, b_data_valid, b_sig_out, b_sig_valid, b_word_count, b_busy} !== 27'h0) begin
         failures++;
         $display("FAIL reset_outputs_b got=%h want=0",
                  {b_data_out, b_data_valid, b_sig_out, b_sig_valid, b_word_count, b_busy});
      end
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b1;
      @(negedge ap_clk);
      ch_write = 2'b11; ch_din = {32'h1, 32'h2};
      @(negedge ap_clk);
      ch_write = 2'b00;
      checks++;
      if (word_count !== 16'd2 || busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_prerun got count=%0d busy=%b want count=2 busy=1", word_count, busy);
      end
      #2 ap_rst_n = 1'b0;
      #1;
      checks++;
      if ({data_out, data_valid, sig_out, sig_valid, word_count, busy} !== 39'h0) begin
         failures++;
         $display("FAIL reset_async got=%h want=0",
                  {data_out, data_valid, sig_out, sig_valid, word_count, busy});
      end
      ap_start = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle got busy=%b want 0", busy);
      end
      ap_start = 1'b1;
      @(negedge ap_clk);
      checks++;
      if (busy !== 1'b1 || word_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_restart got busy=%b count=%0d want busy=1 count=0", busy, word_count);
      end
      ch_write = 2'b01; ch_din = 64'h5;
      @(negedge ap_clk);
      ch_write = 2'b00;
      checks++;
      if (word_count !== 16'd1) begin
         failures++;
         $display("FAIL reset_clean_count got=%0d want=1", word_count);
      end
      ap_done = 1'b1;
      @(negedge ap_clk);
      ap_done = 1'b0;
      repeat (6) @(negedge ap_clk);
      ap_start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_run_closed got busy=%b want 0", busy);
      end
   endtask

   task automatic test_fold();
      logic [1:0]  tw [6] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b11, 2'b00};
      logic [63:0] td [6] = '{{32'hDEADBEEF, 32'h12345678}, 64'h0,
                              {32'h0000000F, 32'h000000FF}, {32'h11223344, 32'hFFFFFFFF},
                              {32'h00000080, 32'h80000001}, 64'h0};
      exp_t        e;
      logic [7:0]  x;
      for (int k = 0; k < 12; k++) begin
         if (data_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL fold_unexpected got=%h want=none", data_out);
            end else begin
               e = sb.pop_front();
               if (data_out !== e.d || cyc != e.due) begin
                  failures++;
                  $display("FAIL fold_word got=%h@%0d want=%h@%0d", data_out, cyc, e.d, e.due);
               end
            end
         end else begin
            checks++;
            if (data_out !== 4'h0 || data_valid !== 1'b0 || (sb.size() > 0 && sb[0].due <= cyc)) begin
               failures++;
               $display("FAIL fold_idle got data=%h valid=%b want data=0 valid=0 pending=%0d",
                        data_out, data_valid, sb.size());
            end
         end
         if (k < 6) begin
            ch_write = tw[k]; ch_din = td[k];
            if (|tw[k]) begin
               x = '0;
               if (tw[k][0]) x ^= fold8(td[k][31:0]);
               if (tw[k][1]) x ^= fold8(td[k][63:32]);
               sb.push_back('{d: fold4(x), due: cyc + 3});
            end
         end else begin
            ch_write = 2'b00;
         end
         @(negedge ap_clk);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL fold_drain got pending=%0d want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      logic [7:0]  x;
      logic [1:0]  w;
      logic [63:0] d;
      for (int k = 0; k < 24; k++) begin
         if (data_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL b2b_unexpected got=%h want=none", data_out);
            end else begin
               e = sb.pop_front();
               if (data_out !== e.d || cyc != e.due) begin
                  failures++;
                  $display("FAIL b2b_word got=%h@%0d want=%h@%0d", data_out, cyc, e.d, e.due);
               end
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            failures++;
            $display("FAIL b2b_missing got valid=0 want=%h@%0d", sb[0].d, sb[0].due);
            void'(sb.pop_front());
         end
         if (k < 18) begin
            w = 2'($urandom_range(1, 3));
            d = {32'($urandom), 32'($urandom)};
            ch_write = w; ch_din = d;
            x = '0;
            if (w[0]) x ^= fold8(d[31:0]);
            if (w[1]) x ^= fold8(d[63:32]);
            sb.push_back('{d: fold4(x), due: cyc + 3});
         end else begin
            ch_write = 2'b00;
         end
         @(negedge ap_clk);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL b2b_drain got pending=%0d want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_signature();
      logic [15:0] s;
      s = '0;
      repeat (3) s = rotl(s) ^ 16'h0008;
      ap_start = 1'b1;
      @(negedge ap_clk);
      checks++;
      if (busy !== 1'b1 || word_count !== 16'd0) begin
         failures++;
         $display("FAIL sig_run_entry got busy=%b count=%0d want busy=1 count=0", busy, word_count);
      end
      ch_write = 2'b11; ch_din = {32'h0, 32'h8};
      @(negedge ap_clk);
      @(negedge ap_clk);
      ap_done = 1'b1;
      @(negedge ap_clk);
      ap_done = 1'b0; ch_write = 2'b00;
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (i < 4) begin
            if (sig_valid !== 1'b0 || busy !== 1'b1) begin
               failures++;
               $display("FAIL sig_drain_%0d got sig_valid=%b busy=%b want 0/1", i, sig_valid, busy);
            end
            @(negedge ap_clk);
         end else begin
            if (sig_valid !== 1'b1 || sig_out !== s || word_count !== 16'd6 || busy !== 1'b0) begin
               failures++;
               $display("FAIL sig_report got valid=%b sig=%h count=%0d busy=%b want 1 %h 6 0",
                        sig_valid, sig_out, word_count, busy, s);
            end
         end
      end
      @(negedge ap_clk);
      checks++;
      if (sig_valid !== 1'b0 || sig_out !== s || word_count !== 16'd6) begin
         failures++;
         $display("FAIL sig_hold got valid=%b sig=%h count=%0d want 0 %h 6",
                  sig_valid, sig_out, word_count, s);
      end
      ap_start = 1'b0;
   endtask

   task automatic test_fsm_edges();
      int n;
      ap_done = 1'b1;
      @(negedge ap_clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL fsm_done_idle got busy=%b want 0", busy);
      end
      ap_start = 1'b1;
      @(negedge ap_clk);
      ap_done = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL fsm_start_done got busy=%b want 1", busy);
      end
      repeat (5) @(negedge ap_clk);
      checks++;
      if (busy !== 1'b1 || sig_valid !== 1'b0 || word_count !== 16'd0) begin
         failures++;
         $display("FAIL fsm_stay_run got busy=%b sig_valid=%b count=%0d want 1 0 0",
                  busy, sig_valid, word_count);
      end
      ch_write = 2'b01; ch_din = {32'h0, 32'h8};
      @(negedge ap_clk);
      ch_write = 2'b00;
      ap_start = 1'b0;
      @(negedge ap_clk);
      ap_start = 1'b1;
      @(negedge ap_clk);
      checks++;
      if (word_count !== 16'd1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL fsm_restart_ignored got count=%0d busy=%b want 1 1", word_count, busy);
      end
      ap_done = 1'b1;
      @(negedge ap_clk);
      ap_done = 1'b0;
      n = 0;
      while (sig_valid !== 1'b1 && n < 10) begin
         @(negedge ap_clk);
         n++;
      end
      checks++;
      if (n != 3 || sig_out !== 16'h0008 || word_count !== 16'd1) begin
         failures++;
         $display("FAIL fsm_report got wait=%0d sig=%h count=%0d want 3 0008 1", n, sig_out, word_count);
      end
      ap_start = 1'b0;
      repeat (3) @(negedge ap_clk);
   endtask

   task automatic test_compact3();
      logic [2:0]  tw [7] = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b111, 3'b011, 3'b110};
      logic [95:0] td [7] = '{{32'hA5, 32'h0, 32'h0}, 96'h0, {32'hA5, 32'h0, 32'h0}, 96'h0,
                              {32'h04, 32'h02, 32'h01}, {32'h0, 32'h0D, 32'h30},
                              {32'h00010000, 32'h00000100, 32'h0}};
      logic [15:0] s;
      logic [7:0]  x;
      exp_t        e;
      int          n;
      s = '0;
      repeat (20) s = rotl(s) ^ 16'h0001;
      b_start = 1'b1;
      @(negedge ap_clk);
      b_write = 3'b001; b_din = 96'h1;
      for (int i = 0; i < 20; i++) begin
         b_done = (i == 19);
         @(negedge ap_clk);
      end
      b_done = 1'b0; b_write = 3'b000;
      n = 0;
      while (b_sig_valid !== 1'b1 && n < 12) begin
         @(negedge ap_clk);
         n++;
      end
      checks++;
      if (n != 4 || b_word_count !== 4'd15 || b_sig_out !== s) begin
         failures++;
         $display("FAIL sat_report got wait=%0d count=%0d sig=%h want 4 15 %h", n, b_word_count, b_sig_out, s);
      end
      b_start = 1'b0;
      repeat (2) @(negedge ap_clk);
      for (int k = 0; k < 13; k++) begin
         if (b_data_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL ch3_unexpected got=%h want=none", b_data_out);
            end else begin
               e = sb.pop_front();
               if (b_data_out !== e.d || cyc != e.due) begin
                  failures++;
                  $display("FAIL ch3_word got=%h@%0d want=%h@%0d", b_data_out, cyc, e.d, e.due);
               end
            end
         end else begin
            checks++;
            if (b_data_out !== 4'h0 || (sb.size() > 0 && sb[0].due <= cyc)) begin
               failures++;
               $display("FAIL ch3_idle got data=%h valid=0 want data=0 pending=%0d", b_data_out, sb.size());
            end
         end
         if (k < 7) begin
            b_write = tw[k]; b_din = td[k];
            if (|tw[k]) begin
               x = '0;
               for (int c = 0; c < 3; c++) if (tw[k][c]) x ^= fold8(td[k][c*32 +: 32]);
               sb.push_back('{d: fold4(x), due: cyc + 4});
            end
         end else begin
            b_write = 3'b000;
         end
         @(negedge ap_clk);
      end
      checks++;
      if (sb.size() != 0 || b_word_count !== 4'd15 || b_sig_out !== s || b_busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_writes got pending=%0d count=%0d sig=%h busy=%b want 0 15 %h 0",
                  sb.size(), b_word_count, b_sig_out, b_busy, s);
         sb.delete();
      end
   endtask

   initial begin
      test_reset();
      test_fold();
      test_back_to_back();
      test_signature();
      test_fsm_edges();
      test_compact3();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
